// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter for instruction fetch and data access
// One access in flight at a time; data wins ties, halted blocks new grants.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        halted,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_we,
  input  logic [31:0] m_rdata,
  output logic        core_stall
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      m_addr_q   <= 32'd0;
      m_wdata_q  <= 32'd0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (!halted) begin
          if (d_req) begin
            owner_d   = 1'b1;
            we_d      = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            cnt_d     = LAT_M1;
            state_d   = WAIT;
          end else if (if_req) begin
            owner_d  = 1'b0;
            we_d     = 1'b0;
            m_addr_d = if_addr;
            cnt_d    = LAT_M1;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // Stores never touch the read-data registers.
          if (!we_q) begin
            if (owner_q) d_rdata_d = m_rdata;
            else         if_rdata_d = m_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The counter only equals LAT_M1 in WAIT on the first cycle after grant.
  assign m_we       = (state_q == WAIT) && we_q && (cnt_q == LAT_M1);
  assign if_ack     = (state_q == RESP) && !owner_q;
  assign d_ack      = (state_q == RESP) && owner_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign core_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Table of accesses with a scoreboard, plus tie, halt, reset and latency sequences.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        halted;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [31:0] m_rdata;
  logic        core_stall;
  logic [31:0] addr_d1;

  logic        lreq;
  logic        lzero = 1'b0;
  logic [31:0] lzero32 = 32'd0;
  logic [31:0] laddr = 32'h0000_0500;
  logic [31:0] lrdata = 32'h0F0F_1234;
  logic [31:0] l1_if_rdata, l1_d_rdata, l1_m_addr, l1_m_wdata;
  logic        l1_if_ack, l1_d_ack, l1_m_we, l1_stall;
  logic [31:0] l15_if_rdata, l15_d_rdata, l15_m_addr, l15_m_wdata;
  logic        l15_if_ack, l15_d_ack, l15_m_we, l15_stall;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;
  vec_t vecs[7];

  logic [31:0] exp_if_last = 32'd0;
  logic [31:0] exp_d_last = 32'd0;

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst_b(rst_b), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata),
    .core_stall(core_stall)
  );

  mem_port_arbiter #(.MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst_b(rst_b), .halted(lzero),
    .if_req(lreq), .if_addr(laddr), .if_rdata(l1_if_rdata), .if_ack(l1_if_ack),
    .d_req(lzero), .d_we(lzero), .d_addr(lzero32), .d_wdata(lzero32),
    .d_rdata(l1_d_rdata), .d_ack(l1_d_ack),
    .m_addr(l1_m_addr), .m_wdata(l1_m_wdata), .m_we(l1_m_we), .m_rdata(lrdata),
    .core_stall(l1_stall)
  );

  mem_port_arbiter #(.MEM_LAT(15)) u_lat15 (
    .clk(clk), .rst_b(rst_b), .halted(lzero),
    .if_req(lreq), .if_addr(laddr), .if_rdata(l15_if_rdata), .if_ack(l15_if_ack),
    .d_req(lzero), .d_we(lzero), .d_addr(lzero32), .d_wdata(lzero32),
    .d_rdata(l15_d_rdata), .d_ack(l15_d_ack),
    .m_addr(l15_m_addr), .m_wdata(l15_m_wdata), .m_we(l15_m_we), .m_rdata(lrdata),
    .core_stall(l15_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2008_000A;
    return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
  endfunction

  // Memory with LAT=2: the data for an address appears one register stage later.
  always @(posedge clk) addr_d1 <= m_addr;
  assign m_rdata = mem_f(addr_d1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_b && (if_ack || d_ack)) begin
      check("ack_onehot", 32'(if_ack & d_ack), 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("ack_port", 32'(d_ack), 32'(e.port));
        if (e.port) check("d_rdata", d_rdata, e.rdata);
        else        check("if_rdata", if_rdata, e.rdata);
      end
    end
  end

  task automatic push_exp(input logic is_d, input logic we, input logic [31:0] addr);
    exp_t e;
    e.port = is_d;
    if (is_d && we) begin
      e.rdata = exp_d_last;
    end else begin
      e.rdata = mem_f(addr);
      if (is_d) exp_d_last = e.rdata;
      else      exp_if_last = e.rdata;
    end
    sbq.push_back(e);
  endtask

  task automatic do_access(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int start;
    int lat;
    int we_cnt;
    @(negedge clk);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    push_exp(is_d, we, addr);
    start = cyc;
    lat = -1;
    we_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_we) begin
        we_cnt++;
        check("m_wdata", m_wdata, wdata);
      end
      if ((is_d && d_ack) || (!is_d && if_ack)) begin
        lat = cyc - start;
        break;
      end
    end
    check("latency", lat, LAT + 1);
    check("m_addr", m_addr, addr);
    check("m_we_cycles", we_cnt, (is_d && we) ? 32'd1 : 32'd0);
    check("stall_in_ack", 32'(core_stall), 32'd0);
    d_req = 1'b0;
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, lat, dlat, iflat, seen, lat1, lat15;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0304, 32'h1234_5678};
    vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0};

    rst_b = 1'b0; halted = 1'b0; lreq = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_d_rdata", d_rdata, 32'd0);
    check("rst_acks", 32'({if_ack, d_ack}), 32'd0);
    rst_b = 1'b1;

    for (int i = 0; i < 7; i++)
      do_access(vecs[i].is_d, vecs[i].we, vecs[i].addr, vecs[i].wdata);

    // Simultaneous requests: data first, fetch after a full access.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0048;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
    push_exp(1'b1, 1'b0, 32'h0000_0100);
    push_exp(1'b0, 1'b0, 32'h0000_0048);
    start = cyc; dlat = -1; iflat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_ack) begin
        dlat = cyc - start;
        check("tie_stall_at_dack", 32'(core_stall), 32'd1);
        d_req = 1'b0;
      end
      if (if_ack) begin
        iflat = cyc - start;
        if_req = 1'b0;
        break;
      end
    end
    check("tie_d_lat", dlat, 32'd3);
    check("tie_if_lat", iflat, 32'd7);

    // Halt raised during a load's WAIT, with the load's req dropped and addr changed.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0140;
    push_exp(1'b1, 1'b0, 32'h0000_0140);
    start = cyc;
    @(negedge clk);
    d_req = 1'b0; d_addr = 32'hDEAD_0000;
    if_req = 1'b1; if_addr = 32'h0000_0084; halted = 1'b1;
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (d_ack) begin lat = cyc - start; break; end
      @(negedge clk);
    end
    check("halt_load_lat", lat, 32'd3);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (if_ack || m_we) seen++;
    end
    check("halt_no_grant", seen, 32'd0);
    check("halt_m_addr", m_addr, 32'h0000_0140);
    check("halt_stall", 32'(core_stall), 32'd1);
    halted = 1'b0;
    push_exp(1'b0, 1'b0, 32'h0000_0084);
    start = cyc; lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_ack) begin lat = cyc - start; break; end
    end
    check("unhalt_if_lat", lat, 32'd3);
    if_req = 1'b0;

    // Reset during the first WAIT cycle of a store.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    check("pre_rst_m_we", 32'(m_we), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("mid_rst_m_we", 32'(m_we), 32'd0);
    check("mid_rst_m_addr", m_addr, 32'd0);
    check("mid_rst_m_wdata", m_wdata, 32'd0);
    check("mid_rst_if_rdata", if_rdata, 32'd0);
    check("mid_rst_d_rdata", d_rdata, 32'd0);
    check("mid_rst_acks", 32'({if_ack, d_ack}), 32'd0);
    exp_if_last = 32'd0; exp_d_last = 32'd0;
    d_req = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0080;
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0000_0080);
    start = cyc; lat = -1; seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (m_we || d_ack) seen++;
      if (if_ack) begin lat = cyc - start; break; end
    end
    check("post_rst_if_lat", lat, 32'd3);
    check("post_rst_no_store", seen, 32'd0);
    if_req = 1'b0;

    // Latency extremes.
    @(negedge clk);
    lreq = 1'b1;
    start = cyc; lat1 = -1; lat15 = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (l1_if_ack && lat1 < 0) lat1 = cyc - start;
      if (l15_if_ack && lat15 < 0) begin lat15 = cyc - start; break; end
    end
    lreq = 1'b0;
    check("lat1_ack", lat1, 32'd2);
    check("lat15_ack", lat15, 32'd16);
    check("lat1_rdata", l1_if_rdata, 32'h0F0F_1234);
    check("lat15_rdata", l15_if_rdata, 32'h0F0F_1234);

    repeat (5) @(negedge clk);
    check("sb_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 2, memory read latency in cycles; legal range 1..15.
REQ-002 clk  input  1  core clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  reset; asynchronous and active-low.
REQ-004 halted  input  1  core halted; blocks new grants.
REQ-005 if_req  input  1  instruction-fetch request; held high until if_ack.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_rdata  output  32  fetched instruction word.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data request; held high until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_rdata  output  32  load data.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 m_addr  output  32  shared memory address.
REQ-016 m_wdata  output  32  shared memory write data.
REQ-017 m_we  output  1  shared memory write strobe.
REQ-018 m_rdata  input  32  shared memory read data, valid MEM_LAT cycles after m_addr is presented.
REQ-019 core_stall  output  1  core pipeline stall.

Function
REQ-020 The block SHALL implement states IDLE, WAIT, RESP plus a 4-bit latency counter and a 1-bit owner register (0 = fetch, 1 = data).
REQ-021 In IDLE with halted=0, the block SHALL grant data when d_req=1, otherwise fetch when if_req=1, otherwise remain in IDLE; data always wins a simultaneous request.
REQ-022 On grant, the block SHALL latch the owner's address into m_addr, and for data also latch d_wdata into m_wdata and d_we into an internal we register; fetch grants latch we=0.
REQ-023 On grant, the block SHALL enter WAIT and load the counter with MEM_LAT-1.
REQ-024 m_we SHALL be high only during the first WAIT cycle of a store grant; it is 0 in every other cycle.
REQ-025 In WAIT, the counter SHALL decrement each cycle; at counter=0 the block SHALL sample m_rdata into the owner's rdata register (loads and fetches only) and enter RESP.
REQ-026 In RESP, the block SHALL assert exactly the owner's ack for that one cycle, then return to IDLE.
REQ-027 Timing: req sampled at edge E, so m_addr is valid from E; m_rdata is sampled at edge E+MEM_LAT; ack is high in the cycle following E+MEM_LAT; one access occupies MEM_LAT+2 cycles.
REQ-028 if_rdata and d_rdata SHALL hold their values until overwritten by a later fetch or load of the same port; a store SHALL leave d_rdata unchanged.
REQ-029 m_addr and m_wdata SHALL hold their latched values until the next grant.
REQ-030 Requester inputs changing while the block is in WAIT or RESP SHALL have no effect on the access in flight.
REQ-031 core_stall SHALL be the combinational value (if_req & ~if_ack) | (d_req & ~d_ack).
REQ-032 halted=1 SHALL suppress new grants in IDLE; an access already in WAIT or RESP SHALL complete normally.
REQ-033 A requester that drops req before its ack SHALL still receive the ack pulse.

Reset
REQ-034 While rst_b=0, the block SHALL force state IDLE, counter 0, owner 0, m_addr 0, m_wdata 0, m_we 0, if_rdata 0, d_rdata 0, if_ack 0, d_ack 0.
REQ-035 Reset asserted mid-access SHALL abandon the access immediately with no ack and no further m_we.
REQ-036 The first grant after reset release SHALL occur at the first rising edge with rst_b=1.

Verification
REQ-037 Fetch only (MEM_LAT=2): if_req=1, if_addr=0x40, m_rdata=0x2008000A at the sample edge -> m_addr=0x40, if_ack pulses at cycle 3, if_rdata=0x2008000A, core_stall=0 in the ack cycle.
REQ-038 Simultaneous requests: if_req=d_req=1 with d_we=0, d_addr=0x100 -> data is served first (d_ack at cycle 3), then the fetch is granted in IDLE (if_ack at cycle 7).
REQ-039 Store: d_we=1, d_addr=0x200, d_wdata=0xDEADBEEF -> m_we high for exactly 1 cycle with m_wdata=0xDEADBEEF, d_ack pulses, d_rdata unchanged.
REQ-040 Reset mid-WAIT: rst_b=0 during the first WAIT cycle of a store -> m_we=0, no ack, every output at its REQ-034 value; after release, an if_req is served normally.
REQ-041 Halt: halted=1 raised during the WAIT of a load with if_req=1 pending -> the load acks; no further grant occurs, m_addr is unchanged, and core_stall=1.
REQ-042 MEM_LAT=1 and MEM_LAT=15 -> the ack occurs MEM_LAT+1 cycles after the grant edge in both cases.
